// File: rtl/mac_accumulator.sv
// mac_accumulator: sums each group of LEN products into one result with a sticky overflow flag.
// Result appears one cycle after the last accept; define MAC_ACC_SATURATE_EN to saturate instead of wrap.
module mac_accumulator #(
  parameter int PROD_W = 10,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_cout,
  input  logic              in_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {ST_ACCUM = 1'b0, ST_DONE = 1'b1} state_t;

  state_t            r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_sum;
  logic              r_out_ovf;

  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  w_acc_next;
  logic              w_ovf_next;
  logic              w_last;
  logic              w_accept;

  assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(in_product);

`ifdef MAC_ACC_SATURATE_EN
  // Once pinned at all-ones, every later add carries again, so the value sticks for the group.
  assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  assign w_ovf_next = r_ovf | w_sum[ACC_W] | in_cout;
  assign w_last     = (r_cnt == CNT_W'(LEN - 1));
  assign in_ready   = (r_state == ST_ACCUM);
  assign w_accept   = in_valid && in_ready;

  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_overflow = r_out_ovf;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (in_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end else if (w_accept) begin
            if (w_last) begin
              r_out_sum   <= w_acc_next;
              r_out_ovf   <= w_ovf_next;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_ovf       <= 1'b0;
              r_state     <= ST_DONE;
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= r_cnt + CNT_W'(1);
              r_ovf <= w_ovf_next;
            end
          end
        end
        ST_DONE: begin
          // Result is held until taken; in_clear has no meaning here.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: three instances (16b/LEN4, 11b/LEN4, 16b/LEN1) share one input stream.
module tb_mac_accumulator;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic [9:0] in_product;
  logic       in_cout;
  logic       in_clear;
  logic       out_ready;

  logic        d0_rdy, d0_vld, d0_ovf;
  logic [15:0] d0_sum;
  logic        d1_rdy, d1_vld, d1_ovf;
  logic [10:0] d1_sum;
  logic        d2_rdy, d2_vld, d2_ovf;
  logic [15:0] d2_sum;

  mac_accumulator #(.PROD_W(10), .ACC_W(16), .LEN(4)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(d0_rdy),
    .in_product(in_product), .in_cout(in_cout), .in_clear(in_clear),
    .out_valid(d0_vld), .out_ready(out_ready), .out_sum(d0_sum), .out_overflow(d0_ovf));

  mac_accumulator #(.PROD_W(10), .ACC_W(11), .LEN(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(d1_rdy),
    .in_product(in_product), .in_cout(in_cout), .in_clear(in_clear),
    .out_valid(d1_vld), .out_ready(out_ready), .out_sum(d1_sum), .out_overflow(d1_ovf));

  mac_accumulator #(.PROD_W(10), .ACC_W(16), .LEN(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(d2_rdy),
    .in_product(in_product), .in_cout(in_cout), .in_clear(in_clear),
    .out_valid(d2_vld), .out_ready(out_ready), .out_sum(d2_sum), .out_overflow(d2_ovf));

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef MAC_ACC_SATURATE_EN
  localparam int SAT11 = 2047;
  localparam bit SAT_MODE = 1'b1;
`else
  localparam int SAT11 = 1796;
  localparam bit SAT_MODE = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: keeps the true (unbounded) group total and derives the
  // result from it, rather than tracking an ACC_W-bit accumulator.
  int      m_w[3] = '{16, 11, 16};
  int      m_len[3] = '{4, 4, 1};
  bit      m_done[3];
  int      m_n[3];
  longint  m_tot[3];
  bit      m_cout[3];
  bit      m_vld[3];
  longint  m_sum[3];
  bit      m_ovf[3];

  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      longint maxv;
      maxv = (longint'(1) << m_w[k]) - 1;
      if (!reset_n) begin
        m_done[k] = 0; m_n[k] = 0; m_tot[k] = 0; m_cout[k] = 0;
        m_vld[k] = 0; m_sum[k] = 0; m_ovf[k] = 0;
      end else if (!m_done[k]) begin
        if (in_clear) begin
          m_n[k] = 0; m_tot[k] = 0; m_cout[k] = 0;
        end else if (in_valid) begin
          m_tot[k] += longint'(in_product);
          m_cout[k] |= in_cout;
          m_n[k]++;
          if (m_n[k] == m_len[k]) begin
            if (m_tot[k] > maxv)
              m_sum[k] = SAT_MODE ? maxv : (m_tot[k] % (maxv + 1));
            else
              m_sum[k] = m_tot[k];
            m_ovf[k]  = (m_tot[k] > maxv) || m_cout[k];
            m_vld[k]  = 1;
            m_done[k] = 1;
            m_n[k] = 0; m_tot[k] = 0; m_cout[k] = 0;
          end
        end
      end else if (out_ready) begin
        m_vld[k]  = 0;
        m_done[k] = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m0_rdy", 32'(d0_rdy), 32'(!m_done[0]));
    chk("m0_vld", 32'(d0_vld), 32'(m_vld[0]));
    chk("m0_sum", 32'(d0_sum), 32'(m_sum[0]));
    chk("m0_ovf", 32'(d0_ovf), 32'(m_ovf[0]));
    chk("m1_rdy", 32'(d1_rdy), 32'(!m_done[1]));
    chk("m1_vld", 32'(d1_vld), 32'(m_vld[1]));
    chk("m1_sum", 32'(d1_sum), 32'(m_sum[1]));
    chk("m1_ovf", 32'(d1_ovf), 32'(m_ovf[1]));
    chk("m2_rdy", 32'(d2_rdy), 32'(!m_done[2]));
    chk("m2_vld", 32'(d2_vld), 32'(m_vld[2]));
    chk("m2_sum", 32'(d2_sum), 32'(m_sum[2]));
    chk("m2_ovf", 32'(d2_ovf), 32'(m_ovf[2]));
  endtask

  // Called at a falling edge: drive, cross one rising edge, then compare.
  task automatic cyc(input bit rst, input bit vld, input int prod, input bit co,
                     input bit clr, input bit ordy);
    reset_n    = rst;
    in_valid   = vld;
    in_product = 10'(prod);
    in_cout    = co;
    in_clear   = clr;
    out_ready  = ordy;
    @(negedge clock);
    chk_model();
  endtask

  typedef struct {
    bit rst; bit vld; int prod; bit co; bit clr; bit ordy;
    bit e_rdy; bit e_vld; int e_sum; bit e_ovf; int e_sum11; bit e_ovf11;
  } vec_t;

  vec_t tv[$];

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_product = '0;
    in_cout = 1'b0; in_clear = 1'b0; out_ready = 1'b0;

    //          rst vld prod co clr ordy | rdy vld sum  ovf sum11 ovf11
    tv.push_back('{0, 0,   0, 0, 0, 0,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1, 961, 0, 0, 1,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1, 961, 0, 0, 1,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1, 961, 0, 0, 1,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1, 961, 0, 0, 1,     0, 1, 3844, 0, SAT11, 1});
    tv.push_back('{1, 0,   0, 0, 0, 1,     1, 0, 3844, 0, SAT11, 1});
    tv.push_back('{1, 1,  10, 0, 0, 0,     1, 0, 3844, 0, SAT11, 1});
    tv.push_back('{1, 1,  20, 0, 0, 0,     1, 0, 3844, 0, SAT11, 1});
    tv.push_back('{1, 1,  30, 0, 0, 0,     1, 0, 3844, 0, SAT11, 1});
    tv.push_back('{1, 1,  40, 0, 0, 0,     0, 1,  100, 0,  100, 0});
    for (int i = 0; i < 5; i++)
      tv.push_back('{1, 1,   7, 0, 0, 0,   0, 1,  100, 0,  100, 0});
    tv.push_back('{1, 1,   7, 0, 0, 1,     1, 0,  100, 0,  100, 0});
    tv.push_back('{1, 1, 100, 0, 0, 0,     1, 0,  100, 0,  100, 0});
    tv.push_back('{1, 1, 200, 0, 0, 0,     1, 0,  100, 0,  100, 0});
    tv.push_back('{1, 1, 999, 0, 1, 0,     1, 0,  100, 0,  100, 0});
    tv.push_back('{1, 1,   5, 0, 0, 0,     1, 0,  100, 0,  100, 0});
    tv.push_back('{1, 1,   6, 0, 0, 0,     1, 0,  100, 0,  100, 0});
    tv.push_back('{1, 1,   7, 0, 0, 0,     1, 0,  100, 0,  100, 0});
    tv.push_back('{1, 1,   8, 0, 0, 0,     0, 1,   26, 0,   26, 0});
    tv.push_back('{1, 0,   0, 0, 1, 0,     0, 1,   26, 0,   26, 0});
    tv.push_back('{1, 0,   0, 0, 0, 1,     1, 0,   26, 0,   26, 0});
    tv.push_back('{1, 1,   1, 0, 0, 0,     1, 0,   26, 0,   26, 0});
    tv.push_back('{1, 1,   2, 0, 0, 0,     1, 0,   26, 0,   26, 0});
    tv.push_back('{0, 1,  50, 0, 0, 1,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1,   1, 0, 0, 0,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1,   2, 0, 0, 0,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1,   3, 0, 0, 0,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1,   4, 0, 0, 0,     0, 1,   10, 0,   10, 0});
    tv.push_back('{0, 0,   0, 0, 0, 0,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1,   1, 0, 0, 0,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1,   2, 1, 0, 0,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1,   3, 0, 0, 0,     1, 0,    0, 0,    0, 0});
    tv.push_back('{1, 1,   4, 0, 0, 0,     0, 1,   10, 1,   10, 1});
    tv.push_back('{1, 0,   0, 0, 0, 1,     1, 0,   10, 1,   10, 1});

    @(negedge clock);
    foreach (tv[i]) begin
      cyc(tv[i].rst, tv[i].vld, tv[i].prod, tv[i].co, tv[i].clr, tv[i].ordy);
      chk($sformatf("t%0d_rdy", i),   32'(d0_rdy), 32'(tv[i].e_rdy));
      chk($sformatf("t%0d_vld", i),   32'(d0_vld), 32'(tv[i].e_vld));
      chk($sformatf("t%0d_sum", i),   32'(d0_sum), 32'(tv[i].e_sum));
      chk($sformatf("t%0d_ovf", i),   32'(d0_ovf), 32'(tv[i].e_ovf));
      chk($sformatf("t%0d_vld11", i), 32'(d1_vld), 32'(tv[i].e_vld));
      chk($sformatf("t%0d_sum11", i), 32'(d1_sum), 32'(tv[i].e_sum11));
      chk($sformatf("t%0d_ovf11", i), 32'(d1_ovf), 32'(tv[i].e_ovf11));
    end

    // LEN=1: every accept completes a group; in_cout flags without touching the sum.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 512, 1, 0, 0);
    chk("len1_vld_a", 32'(d2_vld), 32'd1);
    chk("len1_rdy_a", 32'(d2_rdy), 32'd0);
    chk("len1_sum_a", 32'(d2_sum), 32'd512);
    chk("len1_ovf_a", 32'(d2_ovf), 32'd1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("len1_vld_rel", 32'(d2_vld), 32'd0);
    chk("len1_rdy_rel", 32'(d2_rdy), 32'd1);
    cyc(1, 1, 3, 0, 0, 0);
    chk("len1_vld_b", 32'(d2_vld), 32'd1);
    chk("len1_sum_b", 32'(d2_sum), 32'd3);
    chk("len1_ovf_b", 32'(d2_ovf), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 9) < 7),
          int'($urandom_range(0, 1023)),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream consumer of the 5x5 Wallace tree multiplier.
- Accepts a stream of 10-bit products plus the multiplier carry-out over a valid/ready handshake.
- Sums each group of LEN products into one dot-product result and presents it on a valid/ready output port, with a sticky overflow flag.
- Sits between the combinational multiplier and the downstream result consumer.

Parameters:
- PROD_W, 10: product width; matches the multiplier result width.
- ACC_W, 16: accumulator and output sum width; must satisfy ACC_W >= PROD_W.
- LEN, 4: number of products per group; must be >= 1.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  product on in_product/in_cout is valid.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  PROD_W  multiplier result.
- in_cout  input  1  multiplier carry-out; treated as an error bit.
- in_clear  input  1  abort the current group.
- out_valid  output  1  out_sum/out_overflow hold a completed group.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  group sum.
- out_overflow  output  1  sticky per-group overflow/error flag.

Behaviour:
- Clock/reset: one clock, clock. Reset is synchronous and active-low on reset_n; it is sampled only on the rising edge of clock.
- Reset: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_overflow=0. Reset has priority over every other input, including mid-group and while in DONE.
- FSM has two states, ACCUM and DONE.
- in_ready = 1 exactly when state==ACCUM. It is combinational from state only, never from in_valid.
- Accept occurs when in_valid && in_ready.
- ACCUM, in_clear=1:
  - acc=0, cnt=0, ovf=0; any simultaneous product is dropped.
  - in_clear has priority over accept.
- ACCUM, accept with cnt < LEN-1:
  - acc <= acc + zero-extended in_product.
  - cnt <= cnt+1.
  - ovf <= ovf | carry out of bit ACC_W-1 | in_cout.
- ACCUM, accept with cnt == LEN-1:
  - out_sum <= acc + in_product, with wrap or saturate per the Optional Feature.
  - out_overflow <= combined ovf including this accept.
  - out_valid <= 1; acc, cnt and ovf clear; state <= DONE.
  - Latency: result is visible the cycle after the final accept.
- DONE:
  - out_sum, out_overflow and out_valid are held stable; in_clear is ignored.
  - When out_ready=1: out_valid <= 0, state <= ACCUM, and in_ready=1 on the next cycle. The first accept of the next group can occur one cycle after handoff.
  - out_sum and out_overflow keep their last values after out_valid drops.
- ACCUM, no accept: all state holds.
- Arithmetic:
  - All additions are unsigned and ACC_W+1 bits wide internally; bit ACC_W is the carry.
  - Default mode wraps modulo 2^ACC_W.
- Boundaries:
  - LEN=1: every accept goes straight to DONE.
  - cnt is wide enough for LEN-1, i.e. $clog2(LEN) bits with a minimum of 1.
  - out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro MAC_ACC_SATURATE_EN.
- Defined: when an addition carries out, the accumulator is set to 2^ACC_W-1 and remains there for the rest of the group; out_overflow is still set.
- Not defined: wrap modulo 2^ACC_W; out_overflow still set on carry.
- in_cout sets the flag in both modes but never alters the sum.

Test Plan:
- ACC_W=16, LEN=4. Four products of 961 (31*31), out_ready=1 -> out_valid is high one cycle after the 4th accept, out_sum=3844, out_overflow=0, in_ready=0 during DONE.
- Backpressure. Complete a group, then hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid stays 1, out_sum is stable, in_ready=0, no products are consumed. Raising out_ready -> next-cycle out_valid=0 and in_ready=1.
- Overflow with ACC_W=11, LEN=4, four products of 961:
  - Without macro -> out_sum=1796, out_overflow=1.
  - With MAC_ACC_SATURATE_EN -> out_sum=2047, out_overflow=1.
- Clear mid-group. Accept 100 and 200, then assert in_clear together with in_valid, then send 5, 6, 7, 8 -> out_sum=26, out_overflow=0.
- Reset mid-operation. Drive reset_n=0 after 2 accepts, and separately while in DONE -> next cycle all outputs are 0, in_ready=1, and a following group of 1,2,3,4 gives out_sum=10.
- LEN=1 and in_cout. Send 512 with in_cout=1 -> out_sum=512, out_overflow=1; the next product 3 with in_cout=0 -> out_sum=3, out_overflow=0.
